// File: rtl/mux_rr_reg_if.sv
// Handshake bundle for mux_rr_reg: N request channels in, one registered word out.
// The master modport is the environment side, and the slave modport is the mux side.
interface mux_rr_reg_if #(
   parameter int W = 1,
   parameter int N = 4
);
   localparam int SW = $clog2(N);

   logic          mode;
   logic [SW-1:0] sel;
   logic [N*W-1:0] inData;
   logic [N-1:0]  inValid;
   logic [N-1:0]  inReady;
   logic [W-1:0]  outData;
   logic [SW-1:0] outChan;
   logic          outValid;
   logic          outReady;

   modport master (
      output mode, sel, inData, inValid, outReady,
      input  inReady, outData, outChan, outValid
   );

   modport slave (
      input  mode, sel, inData, inValid, outReady,
      output inReady, outData, outChan, outValid
   );
endinterface

// File: rtl/mux_rr_reg.sv
// N-channel registered mux with direct or round-robin source selection.
// The single-entry output register can be drained and refilled in the same cycle.
module mux_rr_reg #(
   parameter int W = 1,
   parameter int N = 4
) (
   input logic        clk,
   input logic        rst,
   mux_rr_reg_if.slave bus
);
   localparam int SW = $clog2(N);

   logic [W-1:0]  chanWord [N];
   logic [N-1:0]  readyVec;
   logic [SW-1:0] ptrReg;
   logic [SW-1:0] rrGrant;
   logic [SW-1:0] grant;
   logic          directHit;
   logic          rrHit;
   logic          hit;
   logic          loadEn;
   logic          xfer;
   logic [W-1:0]  outDataReg;
   logic [SW-1:0] outChanReg;
   logic          outValidReg;

   for (genvar gi = 0; gi < N; gi++) begin : gChan
      assign chanWord[gi] = bus.inData[gi*W +: W];
      assign readyVec[gi] = xfer && (grant == SW'(gi));
   end

   // An out-of-range select (possible when N is not a power of two) never grants.
   always_comb begin
      directHit = (int'(bus.sel) < N) && bus.inValid[bus.sel];
   end

   // Scan downwards so the channel closest to ptr in cyclic order wins.
   always_comb begin
      int idx;
      rrHit   = 1'b0;
      rrGrant = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptrReg) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (bus.inValid[SW'(idx)]) begin
            rrHit   = 1'b1;
            rrGrant = SW'(idx);
         end
      end
   end

   always_comb begin
      grant  = bus.mode ? rrGrant : bus.sel;
      hit    = bus.mode ? rrHit : directHit;
      loadEn = !outValidReg || bus.outReady;
      xfer   = !rst && hit && loadEn;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outDataReg  <= '0;
         outChanReg  <= '0;
         outValidReg <= 1'b0;
         ptrReg      <= '0;
      end else begin
         if (xfer) begin
            outDataReg  <= chanWord[grant];
            outChanReg  <= grant;
            outValidReg <= 1'b1;
            if (bus.mode) begin
               ptrReg <= (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
            end
         end else if (bus.outReady) begin
            outValidReg <= 1'b0;
         end
      end
   end

   assign bus.inReady  = readyVec;
   assign bus.outData  = outDataReg;
   assign bus.outChan  = outChanReg;
   assign bus.outValid = outValidReg;
endmodule

// File: doc/mux_rr_reg.md
# mux_rr_reg

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. Selects a source either directly from a select bus or by round-robin arbitration over requesting channels, and holds the chosen word in a single-entry output register. It generalises the combinational 4:1 single-bit mux into a stallable pipeline stage for the fault-simulation netlists, with exactly one select-to-output register stage.

## Interface
- W, default 1: data width per channel (>= 1).
- N, default 4: channel count (>= 2).
- SW, derived, ceil(log2(N)): select and channel-index width; not overridable.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SW  channel index used in direct mode.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept (combinational, one-hot or zero).
- out_data  output  W  registered selected word.
- out_chan  output  SW  registered index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts out_data.

## Operation
- State:
  - Output register: out_data, out_chan, out_valid.
  - Round-robin pointer ptr[SW-1:0].
- load_en = !out_valid | out_ready. The register can be refilled in the same cycle it is drained.
- Candidate channel g:
  - Direct mode: g = sel. No candidate if sel >= N or in_valid[sel] = 0.
  - Round-robin mode: g is the first channel with in_valid set, searching cyclically ptr, ptr+1, ..., ptr+N-1 (mod N). No candidate if in_valid is all zero.
- in_ready[g] = load_en when a candidate exists. All other in_ready bits are 0. in_ready is never asserted for a channel whose in_valid is 0.
- Transfer happens when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= in_data[g*W +: W], out_chan <= g, out_valid <= 1.
  - In round-robin mode only, ptr <= (g+1) mod N. N that is not a power of two wraps correctly: N-1 -> 0.
- Drain without refill (out_valid & out_ready, no transfer): out_valid <= 0. out_data and out_chan hold their values.
- Stall (out_valid & !out_ready): all output state holds and in_ready is all zero.
- ptr holds while mode = 0 and in any cycle without a round-robin transfer.
- Mode and sel are sampled every cycle with no setup protocol. A change affects the decision in the same cycle and never corrupts a held word.

## Timing
- Reset, asynchronous:
  - Registers: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
  - in_ready is forced to all zero while rst is high.
- Reset asserted mid-transfer discards the held word. No input is acknowledged during reset.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 word per cycle while out_ready stays high.
- Combinational paths:
  - in_valid, sel, mode and out_ready -> in_ready.
  - No combinational path from any input to out_data, out_chan or out_valid.
- Simultaneous requests from all channels in round-robin mode: grants rotate ptr order, so each channel is granted exactly once every N transfers.
- Accepted word stays stable on out_data until the cycle after out_ready is seen high with out_valid.

## Test plan
- Reset check: assert rst with in_valid all ones. Required: in_ready = 0, out_valid = 0, out_data = 0, ptr = 0. Release rst, hold out_ready = 1. Required: first grant goes to channel 0, with out_valid rising one cycle later.
- Direct mode, N=4, W=8:
  - sel=2, in_data channel 2 = 8'hA5, in_valid = 4'b0100. Required: in_ready = 4'b0100; next cycle out_data = 8'hA5, out_chan = 2.
  - sel=3 with in_valid[3] = 0. Required: in_ready = 0 and out_valid falls after drain.
- Round-robin fairness: N=4, in_valid = 4'b1111, out_ready = 1 for 8 cycles. Required: out_chan sequence 0,1,2,3,0,1,2,3. Then in_valid = 4'b1010 gives alternating 1,3.
- Backpressure: hold out_ready = 0 for 3 cycles after a fill. Required: out_data and out_chan stable, in_ready = 0, ptr unchanged. Raise out_ready with a pending request. Required: drain and refill happen in the same cycle, with no bubble.
- Non-power-of-two wrap: N=3, sel = 3 in direct mode. Required: no grant. Round-robin with all requests from ptr = 2. Required: grant 2, then 0.
- Mid-operation reset: assert rst while out_valid = 1 and out_ready = 0. Required: out_valid drops immediately, asynchronously, not at a clock edge. After release the first grant goes to channel 0 and the old word never appears.
